// File: rtl/md_pkg.sv
// Shared md opcodes, sequencer state encoding and default latencies.
// Imported by the md sequencer and the decode unit.
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MFHI  = 4'd6;
  localparam logic [3:0] MD_MFLO  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_CNT_W       = 4;

endpackage

// File: rtl/md_sequencer_if.sv
// E-stage control bundle between the pipeline and the md sequencer.
// master drives the instruction side, slave is the sequencer.
interface md_sequencer_if;

  logic [3:0] md_op_e;
  logic       valid_e;
  logic       md_use_d;
  logic       b_zero_e;

  logic       start;
  logic       op_signed;
  logic       op_div;
  logic       busy;
  logic       stall_d;
  logic       hi_we;
  logic       lo_we;
  logic       hilo_src;
  logic       done;
  logic       dz_err;
  logic       proto_err;

  modport master (
    output md_op_e, valid_e, md_use_d, b_zero_e,
    input  start, op_signed, op_div, busy, stall_d,
    input  hi_we, lo_we, hilo_src, done, dz_err, proto_err
  );

  modport slave (
    input  md_op_e, valid_e, md_use_d, b_zero_e,
    output start, op_signed, op_div, busy, stall_d,
    output hi_we, lo_we, hilo_src, done, dz_err, proto_err
  );

endinterface

// File: rtl/md_lat_counter.sv
// Down-counter tracking remaining md operation latency.
// Load has priority over decrement; zero flag is combinational.
module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // load a fresh latency or count down toward zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/md_sequencer.sv
// Execute-stage multiply/divide sequencer: start, mode,
// HI/LO strobes, latency tracking, busy and decode stall.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = MD_CNT_W
) (
  input logic           clk,
  input logic           reset,
  md_sequencer_if.slave md
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e state, state_nx;

  logic is_mdv, is_div, is_sgn;
  logic is_mthi, is_mtlo;
  logic start, done, hi_we, lo_we, hilo_src;
  logic load, dec, cnt_zero, proto_set;
  logic op_signed, op_div, dz;
  logic dz_err, proto_err;

  // opcode decode of the E-stage instruction
  always_comb begin
    is_mdv  = 1'b0;
    is_div  = 1'b0;
    is_sgn  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    case (md.md_op_e)
      MD_MULT:  begin is_mdv = 1'b1; is_sgn = 1'b1; end
      MD_MULTU: is_mdv = 1'b1;
      MD_DIV:   begin
        is_mdv = 1'b1;
        is_div = 1'b1;
        is_sgn = 1'b1;
      end
      MD_DIVU:  begin is_mdv = 1'b1; is_div = 1'b1; end
      MD_MTHI:  is_mthi = 1'b1;
      MD_MTLO:  is_mtlo = 1'b1;
      default:  ;
    endcase
  end

  md_lat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (load),
    .load_val (is_div ? DIV_LD : MULT_LD),
    .dec      (dec),
    .zero     (cnt_zero)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // next state and strobes; everything is held low in reset
  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    done      = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hilo_src  = 1'b0;
    load      = 1'b0;
    dec       = 1'b0;
    proto_set = 1'b0;
    if (reset) begin
      unique case (state)
        ST_IDLE: begin
          if (md.valid_e) begin
            if (is_mdv) begin
              start    = 1'b1;
              load     = 1'b1;
              state_nx = ST_RUN;
            end else if (is_mthi) begin
              hi_we    = 1'b1;
              hilo_src = 1'b1;
            end else if (is_mtlo) begin
              lo_we    = 1'b1;
              hilo_src = 1'b1;
            end
          end
        end
        ST_RUN: begin
          proto_set = md.valid_e &
                      (is_mdv | is_mthi | is_mtlo);
          if (cnt_zero) begin
            done     = 1'b1;
            hi_we    = !dz;
            lo_we    = !dz;
            state_nx = ST_IDLE;
          end else begin
            dec = 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // operation mode latched at start, sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_signed <= 1'b0;
      op_div    <= 1'b0;
      dz        <= 1'b0;
      dz_err    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (start) begin
        op_signed <= is_sgn;
        op_div    <= is_div;
        dz        <= md.b_zero_e & is_div;
      end
      if (done && dz)
        dz_err <= 1'b1;
      if (proto_set)
        proto_err <= 1'b1;
    end
  end

  assign md.start     = start;
  assign md.op_signed = op_signed;
  assign md.op_div    = op_div;
  assign md.busy      = start | (state == ST_RUN);
  assign md.stall_d   = md.md_use_d & md.busy;
  assign md.hi_we     = hi_we;
  assign md.lo_we     = lo_we;
  assign md.hilo_src  = hilo_src;
  assign md.done      = done;
  assign md.dz_err    = dz_err;
  assign md.proto_err = proto_err;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: a cycle-numbered model
// queues expected outputs, a negedge monitor checks them.
module tb_md_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  md_sequencer_if bus();

  md_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  typedef struct packed {
    logic start;
    logic busy;
    logic stall;
    logic hi;
    logic lo;
    logic src;
    logic done;
    logic dzerr;
    logic perr;
    logic sgn;
    logic dv;
  } exp_t;

  exp_t q[$];
  int   qc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_n = 0;

  // model: an op in flight finishes at an absolute cycle number
  bit m_act, m_sg, m_dv, m_dz, m_dzerr, m_perr;
  int m_done;

  task automatic step(input logic [3:0] op, input bit v,
                      input bit u, input bit bz, input bit r);
    exp_t e;
    bit   muldiv, chg;
    @(posedge clk);
    #1;
    bus.md_op_e  = op;
    bus.valid_e  = v;
    bus.md_use_d = u;
    bus.b_zero_e = bz;
    reset        = r;
    e      = '0;
    muldiv = (op >= 4'd1) && (op <= 4'd4);
    chg    = muldiv || op == 4'd5 || op == 4'd8;
    if (!r) begin
      m_act = 0; m_sg = 0; m_dv = 0; m_dz = 0;
      m_dzerr = 0; m_perr = 0;
    end else begin
      e.sgn   = m_sg;
      e.dv    = m_dv;
      e.dzerr = m_dzerr;
      e.perr  = m_perr;
      if (m_act) begin
        e.busy = 1;
        if (v && chg) m_perr = 1;
        if (cyc_n == m_done) begin
          e.done = 1;
          e.hi   = !m_dz;
          e.lo   = !m_dz;
          if (m_dz) m_dzerr = 1;
          m_act = 0;
        end
      end else if (v && muldiv) begin
        e.start = 1;
        e.busy  = 1;
        m_act   = 1;
        m_dv    = (op >= 4'd3);
        m_sg    = (op == 4'd1) || (op == 4'd3);
        m_dz    = bz && m_dv;
        m_done  = cyc_n + (m_dv ? 10 : 5);
      end else if (v && op == 4'd5) begin
        e.hi = 1; e.src = 1;
      end else if (v && op == 4'd8) begin
        e.lo = 1; e.src = 1;
      end
      e.stall = u && e.busy;
    end
    q.push_back(e);
    qc.push_back(cyc_n);
    cyc_n++;
  endtask

  task automatic idle(input int n, input bit u);
    for (int i = 0; i < n; i++) step(4'd0, 1'b0, u, 1'b0, 1'b1);
  endtask

  exp_t mon_e, mon_a;
  int   mon_c;

  // monitor: compare every presented output vector with the queue
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_c = qc.pop_front();
      mon_a = {bus.start, bus.busy, bus.stall_d, bus.hi_we,
               bus.lo_we, bus.hilo_src, bus.done, bus.dz_err,
               bus.proto_err, bus.op_signed, bus.op_div};
      tests++;
      if (mon_a !== mon_e) begin
        fails++;
        $display("FAIL cycle%0d outputs got %b want %b (start busy stall hi lo src done dzerr perr sgn div)",
                 mon_c, mon_a, mon_e);
      end
    end
  end

  initial begin
    bus.md_op_e  = 4'd0;
    bus.valid_e  = 1'b0;
    bus.md_use_d = 1'b0;
    bus.b_zero_e = 1'b0;
    // reset held with a valid mult present, then released
    for (int i = 0; i < 3; i++) step(4'd1, 1, 1, 0, 0);
    // mult starts on release, stall watched through done
    step(4'd1, 1, 1, 0, 1);
    idle(6, 1'b1);
    // divu with decode stall, back-to-back divu at t0+11
    step(4'd4, 1, 1, 0, 1);
    idle(10, 1'b1);
    step(4'd4, 1, 1, 0, 1);
    idle(11, 1'b0);
    // divide by zero
    step(4'd3, 1, 0, 1, 1);
    idle(12, 1'b0);
    // mthi at idle, mtlo during run, bubbles with mt ops
    step(4'd5, 1, 0, 0, 1);
    step(4'd2, 1, 0, 0, 1);
    step(4'd8, 1, 0, 0, 1);
    step(4'd6, 1, 0, 0, 1);
    idle(4, 1'b0);
    step(4'd8, 0, 0, 0, 1);
    step(4'd5, 0, 0, 0, 1);
    step(4'd1, 0, 0, 0, 1);
    // reset pulse mid mult, then a clean mult
    step(4'd1, 1, 0, 0, 1);
    idle(2, 1'b0);
    step(4'd0, 0, 0, 0, 0);
    idle(7, 1'b0);
    step(4'd1, 1, 1, 0, 1);
    idle(6, 1'b1);
    // randomized traffic with rare resets
    for (int i = 0; i < 600; i++) begin
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) != 0),
           $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 79) != 0));
    end
    idle(12, 1'b0);
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
